// File: rtl/dz_hatch_seq.sv
// Egg-hatch sequencer: steps egg images on tick, then reveals a random animal or shows failure.
// Optional: define DZ_FAIL_BLINK_EN to make fail_show toggle on each unpaused tick in FAIL.
module dz_hatch_seq #(
  parameter int unsigned STAGES     = 16,
  parameter int unsigned HOLD_TICKS = 3,
  parameter int unsigned FAIL_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic       pause,
  input  logic       fail,
  input  logic [1:0] rand_val,
  output logic       rand_en,
  output logic [3:0] img_num,
  output logic       img_load,
  output logic       fail_show,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntMax = (HOLD_TICKS > FAIL_TICKS) ? HOLD_TICKS : FAIL_TICKS;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StGrow, StReveal, StHold, StFail} state_e;

  state_e          state_q, state_d;
  logic [3:0]      stage_q, stage_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      img_num_q, img_num_d;
  logic            img_load_q, img_load_d;
  logic            fail_show_q, fail_show_d;
  logic            rand_en_q, rand_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic       adv;
  logic [3:0] stage_inc;
  logic [CntW:0] cnt_inc;

  assign adv       = tick && !pause;
  assign stage_inc = stage_q + 4'd1;
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    img_num_d   = img_num_q;
    img_load_d  = 1'b0;
    fail_show_d = fail_show_q;
    rand_en_d   = rand_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StGrow;
          stage_d    = 4'd0;
          img_num_d  = 4'd0;
          img_load_d = 1'b1;
          rand_en_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StGrow: begin
        if (fail) begin
          state_d     = StFail;
          fail_show_d = 1'b1;
          rand_en_d   = 1'b0;
          cnt_d       = '0;
        end else if (tick && stage_q == 4'(STAGES - 1)) begin
          // Last egg stage: pause deliberately does not hold off the reveal.
          state_d   = StReveal;
          rand_en_d = 1'b0;
        end else if (adv) begin
          stage_d    = stage_inc;
          img_num_d  = {1'b0, stage_inc[3:1]};
          img_load_d = ~stage_inc[0];
        end
      end
      StReveal: begin
        state_d    = StHold;
        img_num_d  = 4'd8 + {2'b00, rand_val};
        img_load_d = 1'b1;
        cnt_d      = '0;
      end
      StHold: begin
        if (adv) begin
          if (cnt_inc >= (CntW + 1)'(HOLD_TICKS)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CntW-1:0];
          end
        end
      end
      StFail: begin
        if (adv) begin
          if (cnt_inc >= (CntW + 1)'(FAIL_TICKS)) begin
            state_d     = StIdle;
            fail_show_d = 1'b0;
            img_num_d   = 4'd0;
            img_load_d  = 1'b1;
            busy_d      = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc[CntW-1:0];
`ifdef DZ_FAIL_BLINK_EN
            fail_show_d = ~fail_show_q;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      stage_q     <= 4'd0;
      cnt_q       <= '0;
      img_num_q   <= 4'd0;
      img_load_q  <= 1'b0;
      fail_show_q <= 1'b0;
      rand_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      img_num_q   <= img_num_d;
      img_load_q  <= img_load_d;
      fail_show_q <= fail_show_d;
      rand_en_q   <= rand_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rand_en   = rand_en_q;
  assign img_num   = img_num_q;
  assign img_load  = img_load_q;
  assign fail_show = fail_show_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dz_hatch_seq.sv
// Directed bench for dz_hatch_seq: growth, reveal, fail, pause, busy-ignore and async reset.
module tb_dz_hatch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       fail = 1'b0;
  logic [1:0] rand_val = 2'b00;
  logic       rand_en;
  logic [3:0] img_num;
  logic       img_load;
  logic       fail_show;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  dz_hatch_seq #(
    .STAGES    (16),
    .HOLD_TICKS(3),
    .FAIL_TICKS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tick     (tick),
    .pause    (pause),
    .fail     (fail),
    .rand_val (rand_val),
    .rand_en  (rand_en),
    .img_num  (img_num),
    .img_load (img_load),
    .fail_show(fail_show),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_img"}, img_num, 0);
    check({tag, "_load"}, img_load, 0);
    check({tag, "_fshow"}, fail_show, 0);
    check({tag, "_randen"}, rand_en, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #3;
    check_idle_outputs("rst");
    step();
    step();
    rst = 1'b1;
    step();
    check_idle_outputs("post_rst");

    // Growth sequence
    do_start();
    check("start_busy", busy, 1);
    check("start_img", img_num, 0);
    check("start_load", img_load, 1);
    check("start_randen", rand_en, 1);
    for (int i = 1; i <= 15; i++) begin
      do_tick();
      check($sformatf("grow_img%0d", i), img_num, i >> 1);
      check($sformatf("grow_load%0d", i), img_load, (i % 2 == 0) ? 1 : 0);
    end
    check("grow_randen", rand_en, 1);

    // Reveal and hold, with start/fail ignored in HOLD
    rand_val = 2'b10;
    done_cnt = 0;
    do_tick();
    check("reveal_randen", rand_en, 0);
    check("reveal_busy", busy, 1);
    step();
    check("hold_img", img_num, 10);
    check("hold_load", img_load, 1);
    start = 1'b1;
    fail  = 1'b1;
    step();
    start = 1'b0;
    fail  = 1'b0;
    check("hold_ign_img", img_num, 10);
    check("hold_ign_fshow", fail_show, 0);
    check("hold_ign_busy", busy, 1);
    do_tick();
    do_tick();
    check("hold2_done", done, 0);
    check("hold2_busy", busy, 1);
    do_tick();
    check("hold3_done", done, 1);
    check("hold3_busy", busy, 0);
    step();
    check("after_done", done, 0);
    check("done_once", done_cnt, 1);
    check("idle_img_kept", img_num, 10);
    check("idle_randen", rand_en, 0);

    // Fail at stage 5 together with a tick
    do_start();
    check("restart_img", img_num, 0);
    for (int i = 1; i <= 5; i++) do_tick();
    check("st5_img", img_num, 2);
    fail = 1'b1;
    tick = 1'b1;
    step();
    fail = 1'b0;
    tick = 1'b0;
    check("fail_fshow", fail_show, 1);
    check("fail_img", img_num, 2);
    check("fail_randen", rand_en, 0);
    check("fail_busy", busy, 1);
    for (int k = 1; k <= 3; k++) begin
      do_tick();
`ifdef DZ_FAIL_BLINK_EN
      check($sformatf("fail_fshow_t%0d", k), fail_show, (k % 2 == 0) ? 1 : 0);
`else
      check($sformatf("fail_fshow_t%0d", k), fail_show, 1);
`endif
      check($sformatf("fail_img_t%0d", k), img_num, 2);
      check($sformatf("fail_busy_t%0d", k), busy, 1);
    end
    do_tick();
    check("fail_exit_busy", busy, 0);
    check("fail_exit_img", img_num, 0);
    check("fail_exit_load", img_load, 1);
    check("fail_exit_fshow", fail_show, 0);

    // Pause in GROW at stage 4; start while busy is ignored
    do_start();
    for (int i = 1; i <= 4; i++) do_tick();
    check("st4_img", img_num, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) do_tick();
    pause = 1'b0;
    check("pause_img", img_num, 2);
    do_start();
    check("busy_start_img", img_num, 2);
    check("busy_start_load", img_load, 0);
    do_tick();
    check("st5_after_pause_img", img_num, 2);
    check("st5_after_pause_load", img_load, 0);
    do_tick();
    check("st6_img", img_num, 3);
    check("st6_load", img_load, 1);

    // Asynchronous reset between clock edges mid-GROW
    done_cnt = 0;
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    step();
    step();
    rst = 1'b1;
    step();
    check_idle_outputs("after_async");
    check("async_no_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
